// File: rtl/gpio_trace_fifo.sv
// Records every change of the three GPIO ports, or a trap rising edge, as a timestamped entry in a first-word-fall-through FIFO.
// Define GPIO_TRACE_TS_EN to build the timestamp counter; without it the ts field of each entry is 0.
module gpio_trace_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int TS_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    power_on_reset,
  input  logic [7:0]              gpio0pins,
  input  logic [7:0]              gpio1pins,
  input  logic [7:0]              gpio2pins,
  input  logic                    trap,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [24+TS_WIDTH:0]    rd_data,
  output logic [ADDR_W:0]         count,
  output logic                    overflow,
  output logic [7:0]              drop_count
);

  localparam int              EW       = 25 + TS_WIDTH;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [23:0]         pins_now;
  logic [TS_WIDTH-1:0] ts_now;
  logic [EW-1:0]       entry;
  logic [EW-1:0]       mem_q [DEPTH];

  logic                armed_q, armed_d;
  logic [23:0]         prev_q, prev_d;
  logic                trap_q, trap_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_q, drop_d;

  logic trap_rise, evt, full, pop, push, drop;

  assign pins_now = {gpio2pins, gpio1pins, gpio0pins};

`ifdef GPIO_TRACE_TS_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  // Runs only once armed, so the first armed edge stamps 0.
  always_comb ts_d = armed_q ? ts_q + 1'b1 : ts_q;

  always_ff @(posedge clk or posedge power_on_reset) begin
    if (power_on_reset) ts_q <= '0;
    else                ts_q <= ts_d;
  end

  assign ts_now = ts_q;
`else
  assign ts_now = '0;
`endif

  assign trap_rise = trap & ~trap_q;
  assign evt       = armed_q & ((pins_now != prev_q) | trap_rise);
  assign full      = (count_q == FULL_CNT);
  assign pop       = rd_en & (count_q != '0);
  // A full FIFO still accepts an event when the head leaves on the same edge.
  assign push      = evt & (~full | pop);
  assign drop      = evt & full & ~pop;
  assign entry     = {trap_rise, ts_now, pins_now};

  always_comb begin
    armed_d    = 1'b1;
    prev_d     = pins_now;
    trap_d     = trap;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge power_on_reset) begin
    if (power_on_reset) begin
      armed_q    <= 1'b0;
      prev_q     <= '0;
      trap_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      armed_q    <= armed_d;
      prev_q     <= prev_d;
      trap_q     <= trap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  // Storage is not reset, so an empty FIFO presents zero instead of stale data.
  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_gpio_trace_fifo.sv
// Bench for gpio_trace_fifo: table-driven vectors plus hand sequences, checked against a queue scoreboard.
module tb_gpio_trace_fifo;
  localparam int DEPTH = 16;
  localparam int TSW   = 16;

  logic        clk = 1'b0;
  logic        power_on_reset;
  logic [7:0]  gpio0pins, gpio1pins, gpio2pins;
  logic        trap, rd_en;
  logic        rd_valid;
  logic [24+TSW:0] rd_data;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;

  gpio_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .TS_WIDTH(TSW)) dut (
    .clk(clk), .power_on_reset(power_on_reset),
    .gpio0pins(gpio0pins), .gpio1pins(gpio1pins), .gpio2pins(gpio2pins),
    .trap(trap), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pins;
    logic        trap;
    logic        rd;
    int          exp_count;
    logic        exp_vld;
  } vec_t;

  vec_t        tbl [21];
  logic [40:0] sb [$];
  logic        m_armed, m_trap, m_ovf;
  logic [23:0] m_prev, pat;
  logic [15:0] m_ts;
  logic [7:0]  m_drop;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [40:0] head;
    head = (sb.size() != 0) ? sb[0] : 41'h0;
    chk({tag, ".count"}, 64'(count), 64'(sb.size()));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(sb.size() != 0));
    chk({tag, ".rd_data"}, 64'(rd_data), 64'(head));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".drop_count"}, 64'(drop_count), 64'(m_drop));
  endtask

  task automatic model_reset();
    sb.delete();
    m_armed = 1'b0; m_trap = 1'b0; m_ovf = 1'b0;
    m_prev = '0; m_ts = '0; m_drop = '0;
  endtask

  // Called at a negedge: drive inputs, predict the next posedge, then check at the following negedge.
  task automatic step(input logic [23:0] p, input logic t, input logic r, input string tag);
    logic trise, ev, pop;
    logic [15:0] ts_f;
    {gpio2pins, gpio1pins, gpio0pins} = p;
    trap = t;
    rd_en = r;
    pop = r && (sb.size() != 0);
    trise = t & ~m_trap;
    ev = m_armed && ((p != m_prev) || trise);
`ifdef GPIO_TRACE_TS_EN
    ts_f = m_ts;
`else
    ts_f = '0;
`endif
    if (pop) void'(sb.pop_front());
    if (ev) begin
      if (sb.size() < DEPTH) sb.push_back({trise, ts_f, p});
      else begin
        m_ovf = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
    end
    if (m_armed) m_ts = m_ts + 16'd1;
    m_armed = 1'b1;
    m_prev = p;
    m_trap = t;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic [40:0] exp1;
    for (int i = 0; i < 6; i++) tbl[i] = '{24'h000000, 1'b0, 1'b0, 0, 1'b0};
    tbl[6] = '{24'h000001, 1'b0, 1'b0, 1, 1'b1};
    tbl[7] = '{24'h003C01, 1'b1, 1'b0, 2, 1'b1};
    for (int i = 8; i < 17; i++) tbl[i] = '{24'h003C01, 1'b1, 1'b0, 2, 1'b1};
    tbl[17] = '{24'h003C01, 1'b0, 1'b1, 1, 1'b1};
    for (int i = 18; i < 21; i++) tbl[i] = '{24'h003C01, 1'b0, 1'b1, 0, 1'b0};
`ifdef GPIO_TRACE_TS_EN
    exp1 = {1'b0, 16'd5, 24'h000001};
`else
    exp1 = {1'b0, 16'd0, 24'h000001};
`endif

    power_on_reset = 1'b1;
    {gpio2pins, gpio1pins, gpio0pins} = '0;
    trap = 1'b0;
    rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    power_on_reset = 1'b0;

    // Single change, coincident trap rise, sustained trap, drain, reads on empty.
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].pins, tbl[i].trap, tbl[i].rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_count", i), 64'(count), 64'(tbl[i].exp_count));
      chk($sformatf("vec%0d.tbl_valid", i), 64'(rd_valid), 64'(tbl[i].exp_vld));
      if (i == 6) chk("t1_entry", 64'(rd_data), 64'(exp1));
      if (i == 7) chk("t2_trap_flag", 64'(rd_data[40]), 64'(1'b0));
    end

    // Twenty changes with no reads overrun the FIFO by four.
    pat = 24'h000100;
    for (int i = 0; i < 20; i++) begin
      pat = pat + 24'h1;
      step(pat, 1'b0, 1'b0, "t3_fill");
    end
    chk("t3_count", 64'(count), 64'd16);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_drop", 64'(drop_count), 64'd4);

    // Full FIFO with event and pop on the same edge.
    pat = pat + 24'h1;
    step(pat, 1'b0, 1'b1, "t4_pushpop");
    chk("t4_count", 64'(count), 64'd16);
    chk("t4_drop", 64'(drop_count), 64'd4);

    for (int i = 0; i < 17; i++) step(pat, 1'b0, 1'b1, "t3_drain");
    chk("t3_empty", 64'(rd_valid), 64'd0);

    // Reset asserted while five entries are held.
    for (int i = 0; i < 5; i++) begin
      pat = pat + 24'h1;
      step(pat, 1'b0, 1'b0, "t6_fill");
    end
    #2 power_on_reset = 1'b1;
    model_reset();
    #1;
    check_outputs("t6_async");
    @(negedge clk);
    power_on_reset = 1'b0;
    step(24'hA5A5A5, 1'b1, 1'b0, "t6_arm");
    chk("t6_arm_count", 64'(count), 64'd0);
    step(24'hA5A5A5, 1'b1, 1'b0, "t6_stable");
    step(24'hA5A5A4, 1'b1, 1'b0, "t6_first");

    // Drop counter saturation.
    for (int i = 0; i < 280; i++) begin
      pat = pat + 24'h1;
      step(pat, 1'b0, 1'b0, "sat");
    end
    chk("sat_drop", 64'(drop_count), 64'd255);
    chk("sat_count", 64'(count), 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
